// File: rtl/mmio_pkg.sv
// Shared definitions for the MIPS memory/IO data path: access sizes, IO map and load lane steering.
package mmio_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } access_size_e;

  localparam logic [31:0] IO_BASE_DEF   = 32'hFFFF_FC00;
  localparam logic [9:0]  SW_OFFSET_DEF = 10'h070;

  // Output channel k lives at IO_BASE + 4k.
  function automatic logic [9:0] ch_offset(input int k);
    return 10'(4 * k);
  endfunction

  // Picks the addressed byte/half lane out of a memory word and extends it to 32 bits.
  function automatic logic [31:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  addr,
                                              input access_size_e size,
                                              input logic        zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return zero_ext ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: return zero_ext ? {16'b0, h} : {{16{h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises raw switch pins and only accepts a new value after it has been steady long enough.
module switch_debouncer #(
  parameter int unsigned IN_W            = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] raw,
  output logic [IN_W-1:0] stable
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_W-1:0]  sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q;
  logic [IN_W-1:0]  synced;
  logic [IN_W-1:0]  upcoming;

  assign synced   = sync_q[SYNC_STAGES-1];
  // The stage just behind the output tells us whether the synced value moves on this edge.
  assign upcoming = sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cnt_q  <= '0;
      stable <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (synced == stable || synced != upcoming) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        stable <= synced;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_data_router.sv
// Load/store steering between the core, data memory and memory-mapped LED/tube/switch registers.
module mmio_data_router
  import mmio_pkg::*;
#(
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       NUM_OUT_CH      = 2,
  parameter int unsigned       OUT_W           = 16,
  parameter int unsigned       IN_W            = 16,
  parameter logic [DATA_W-1:0] IO_BASE         = IO_BASE_DEF,
  parameter logic [9:0]        SW_OFFSET       = SW_OFFSET_DEF,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 1000000
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iDoLoad,
  input  logic                        iDoStore,
  input  logic [1:0]                  iAccessSize,
  input  logic                        iLoadUnsigned,
  input  logic [DATA_W-1:0]           iAddress,
  input  logic [DATA_W-1:0]           iStoreData,
  input  logic [DATA_W-1:0]           iMemReadData,
  input  logic [IN_W-1:0]             iSwitch,
  output logic [DATA_W-1:0]           oMemAddress,
  output logic [DATA_W-1:0]           oMemWriteData,
  output logic [3:0]                  oMemByteEnable,
  output logic [DATA_W-1:0]           oLoadData,
  output logic [NUM_OUT_CH*OUT_W-1:0] oOutChannels,
  output logic [IN_W-1:0]             oSwitchStable,
  output logic                        oFault
);

  access_size_e          size;
  logic                  is_io, misaligned, hit_sw, io_bad, bad, active;
  logic [NUM_OUT_CH-1:0] hit_ch;
  logic [3:0]            be_raw;
  logic [DATA_W-1:0]     io_rdata;
  logic [OUT_W-1:0]      ch_q [NUM_OUT_CH];

  assign size        = access_size_e'(iAccessSize);
  assign is_io       = (iAddress[DATA_W-1:10] == IO_BASE[DATA_W-1:10]);
  assign hit_sw      = (iAddress[9:0] == SW_OFFSET);
  assign active      = iDoLoad | iDoStore;
  assign oMemAddress = {iAddress[DATA_W-1:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_HALF: misaligned = iAddress[0];
      SIZE_WORD: misaligned = |iAddress[1:0];
      SIZE_RSVD: misaligned = 1'b1;
      default:   misaligned = 1'b0;
    endcase
  end

  always_comb begin
    hit_ch   = '0;
    io_rdata = '0;
    for (int k = 0; k < NUM_OUT_CH; k++) begin
      hit_ch[k] = (iAddress[9:0] == ch_offset(k));
      if (hit_ch[k]) io_rdata = DATA_W'(ch_q[k]);
    end
    if (hit_sw) io_rdata = DATA_W'(oSwitchStable);
  end

  // Bad accesses (including simultaneous load+store) must leave memory and channels untouched.
  assign io_bad = is_io & ((size != SIZE_WORD) | ~((|hit_ch) | hit_sw));
  assign bad    = misaligned | io_bad | (iDoLoad & iDoStore);

  always_comb begin
    oMemWriteData = iStoreData;
    be_raw        = 4'b0000;
    case (size)
      SIZE_BYTE: begin
        oMemWriteData = {4{iStoreData[7:0]}};
        be_raw        = 4'b0001 << iAddress[1:0];
      end
      SIZE_HALF: begin
        oMemWriteData = {2{iStoreData[15:0]}};
        be_raw        = iAddress[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: be_raw = 4'b1111;
      default:   be_raw = 4'b0000;
    endcase
    oMemByteEnable = (iDoStore & ~bad & ~is_io) ? be_raw : 4'b0000;
  end

  always_comb begin
    oLoadData = '0;
    if (iDoLoad & ~bad)
      oLoadData = is_io ? io_rdata : lane_select(iMemReadData, iAddress[1:0], size, iLoadUnsigned);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int k = 0; k < NUM_OUT_CH; k++) ch_q[k] <= '0;
      oFault <= 1'b0;
    end else begin
      if (iDoStore & ~bad & is_io) begin
        for (int k = 0; k < NUM_OUT_CH; k++)
          if (hit_ch[k]) ch_q[k] <= iStoreData[OUT_W-1:0];
      end
      if (active & bad) oFault <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_OUT_CH; k++) begin : g_out
    assign oOutChannels[k*OUT_W +: OUT_W] = ch_q[k];
  end

  switch_debouncer #(
    .IN_W           (IN_W),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debouncer (
    .clk   (iClock),
    .reset (iReset),
    .raw   (iSwitch),
    .stable(oSwitchStable)
  );

endmodule

// File: tb/tb_mmio_data_router.sv
// Directed plus randomized bench for mmio_data_router against an address-map/window reference model.
module tb_mmio_data_router;
  import mmio_pkg::*;

  localparam int          S    = 2;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst, ld, st, uns;
  logic [1:0]  size;
  logic [31:0] addr, sdata, rdata;
  logic [15:0] sw;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic [31:0] out_ch;
  logic [15:0] sw_stable;
  logic        fault;

  always #5 clk = ~clk;

  mmio_data_router #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .iClock       (clk),
    .iReset       (rst),
    .iDoLoad      (ld),
    .iDoStore     (st),
    .iAccessSize  (size),
    .iLoadUnsigned(uns),
    .iAddress     (addr),
    .iStoreData   (sdata),
    .iMemReadData (rdata),
    .iSwitch      (sw),
    .oMemAddress  (mem_addr),
    .oMemWriteData(mem_wdata),
    .oMemByteEnable(mem_be),
    .oLoadData    (load_data),
    .oOutChannels (out_ch),
    .oSwitchStable(sw_stable),
    .oFault       (fault)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_ch [2];
  logic        m_fault;
  logic [15:0] m_stable;
  logic [15:0] sw_hist [$];

  logic [31:0] e_load, e_wdata;
  logic [3:0]  e_be;
  logic        e_bad, e_io;
  int          e_ioff;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic l, input logic s, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd);
    ld = l; st = s; size = sz; uns = u; addr = a; sdata = sd; rdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic compute_expected();
    int nbytes, off;
    logic [31:0] mask, v;
    logic hit;
    off    = int'(addr % 4);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    e_io   = (addr >= BASE);
    e_ioff = e_io ? int'(addr - BASE) : -1;
    hit    = e_io && (e_ioff == 0 || e_ioff == 4 || e_ioff == 'h70);
    if (nbytes == 0) e_bad = 1'b1;
    else e_bad = (off % nbytes != 0) || (e_io && (nbytes != 4 || !hit)) || (ld && st);
    e_be = 4'b0;
    if (st && !e_bad && !e_io) e_be = 4'(((1 << nbytes) - 1) << off);
    case (nbytes)
      1:       e_wdata = {24'b0, sdata[7:0]} * 32'h0101_0101;
      2:       e_wdata = {16'b0, sdata[15:0]} * 32'h0001_0001;
      default: e_wdata = sdata;
    endcase
    e_load = 32'h0;
    if (ld && !e_bad) begin
      if (e_io) begin
        if (e_ioff == 0)      e_load = {16'b0, m_ch[0]};
        else if (e_ioff == 4) e_load = {16'b0, m_ch[1]};
        else                  e_load = {16'b0, m_stable};
      end else if (nbytes == 4) begin
        e_load = rdata;
      end else begin
        mask = (32'd1 << (8 * nbytes)) - 32'd1;
        v    = (rdata >> (8 * off)) & mask;
        if (!uns && v[8*nbytes-1]) v = v | ~mask;
        e_load = v;
      end
    end
  endtask

  task automatic model_edge();
    int top;
    logic [15:0] v;
    bit same;
    if (rst) begin
      m_ch[0] = 16'h0; m_ch[1] = 16'h0; m_fault = 1'b0; m_stable = 16'h0;
      sw_hist.delete();
      repeat (D + S) sw_hist.push_back(16'h0);
    end else begin
      // Accept a value once D+1 consecutive synchronised samples agree and differ from the current one.
      top  = sw_hist.size() - 1 - (S - 2);
      v    = sw_hist[top];
      same = 1'b1;
      for (int t = 1; t <= D; t++) if (sw_hist[top-t] != v) same = 1'b0;
      if (same && v != m_stable) m_stable = v;
      sw_hist.push_back(sw);
      if (sw_hist.size() > D + S) void'(sw_hist.pop_front());
      if (st && !e_bad && e_io && e_ioff == 0) m_ch[0] = sdata[15:0];
      if (st && !e_bad && e_io && e_ioff == 4) m_ch[1] = sdata[15:0];
      if ((ld || st) && e_bad) m_fault = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    compute_expected();
    check("mem_addr", mem_addr, addr & ~32'd3);
    check("byte_en", 32'(mem_be), 32'(e_be));
    if (e_be != 4'b0) check("write_data", mem_wdata, e_wdata);
    check("load_data", load_data, e_load);
    @(posedge clk);
    model_edge();
    #1;
    check("ch0", 32'(out_ch[15:0]), 32'(m_ch[0]));
    check("ch1", 32'(out_ch[31:16]), 32'(m_ch[1]));
    check("fault", 32'(fault), 32'(m_fault));
    check("switch_stable", 32'(sw_stable), 32'(m_stable));
  endtask

  initial begin
    int k;
    rst = 1'b1; sw = 16'h0; idle();
    tick(); tick();
    rst = 1'b0;
    check("reset_ch", out_ch, 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    check("reset_stable", 32'(sw_stable), 32'h0);

    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'hA5, 32'h0); #1;
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 32'h8000_0000); #1;
    check("lb", load_data, 32'hFFFF_FF80);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h8000_0000); #1;
    check("lbu", load_data, 32'h0000_0080);
    tick();
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h6, 32'h1234, 32'h0); #1;
    check("sh_be", 32'(mem_be), 32'hC);
    tick();
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 32'h8001_0000); #1;
    check("lh", load_data, 32'hFFFF_8001);
    tick();

    drive(1'b0, 1'b1, 2'd2, 1'b0, BASE, 32'h0000_BEEF, 32'h0); #1;
    check("io_sw_be", 32'(mem_be), 32'h0);
    tick();
    drive(1'b0, 1'b1, 2'd2, 1'b0, BASE + 4, 32'h0000_0F0F, 32'h0);
    tick();
    check("io_ch0", 32'(out_ch[15:0]), 32'hBEEF);
    check("io_ch1", 32'(out_ch[31:16]), 32'h0F0F);
    drive(1'b1, 1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, 32'hDEAD_BEEF); #1;
    check("io_lw", load_data, 32'h0000_0F0F);
    tick();

    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h2, 32'h1111_1111, 32'h0); #1;
    check("mis_be", 32'(mem_be), 32'h0);
    tick();
    check("mis_fault", 32'(fault), 32'h1);
    idle(); tick();
    check("fault_held", 32'(fault), 32'h1);
    drive(1'b0, 1'b1, 2'd1, 1'b0, BASE, 32'h2222, 32'h0);
    tick();
    check("io_sh_ch0", 32'(out_ch[15:0]), 32'hBEEF);
    check("io_sh_fault", 32'(fault), 32'h1);

    idle();
    sw = 16'h00FF; repeat (4) tick();
    sw = 16'h0000; repeat (3) tick();
    check("glitch_hold", 32'(sw_stable), 32'h0);
    sw = 16'h00FF;
    k = 0;
    while (k < 40 && sw_stable != 16'h00FF) begin
      tick();
      k++;
    end
    check("debounce_latency", 32'(k), 32'(S + D));
    drive(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h70, 32'h0, 32'h0); #1;
    check("sw_lw", load_data, 32'h0000_00FF);
    tick();

    idle();
    sw = 16'h0A0A; repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_ch", out_ch, 32'h0);
    check("rst_stable", 32'(sw_stable), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    for (int i = 0; i < 500; i++) begin
      int r;
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 255));
        2:       a = $urandom();
        3:       a = BASE;
        4:       a = BASE + 32'd4;
        default: a = BASE + 32'($urandom_range(0, 'h80));
      endcase
      r = $urandom_range(0, 9);
      drive(r < 4 || r == 9, (r >= 4 && r < 8) || r == 9, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom(), $urandom());
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom());
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_data_router.md
Name: mmio_data_router

Overview:
- Parametrised memory/IO data path between the single-cycle MIPS core and the data memory plus board peripherals (LEDs, seven-segment tubes, switches).
- Decodes the ALU address into data memory or a memory-mapped IO region.
- Performs byte, halfword and word loads and stores with lane steering and sign extension.
- Holds registered output-channel values, debounces the switch input, and flags misaligned or illegal accesses.

Parameters:
- DATA_W, 32, core data/address width
- NUM_OUT_CH, 2, number of registered output channels (ch0 LED, ch1 tube)
- OUT_W, 16, width of each output channel
- IN_W, 16, switch input width
- IO_BASE, 32'hFFFF_FC00, base of IO region; region = address bits [31:10] equal IO_BASE[31:10]
- SW_OFFSET, 10'h070, switch register offset inside IO region
- SYNC_STAGES, 2, switch synchroniser flops (≥2)
- DEBOUNCE_CYCLES, 20'd1000000, cycles a new switch value must be stable before acceptance

Ports:
- iClock, input, 1, system clock, rising edge
- iReset, input, 1, synchronous, active-high reset
- iDoLoad, input, 1, load instruction this cycle
- iDoStore, input, 1, store instruction this cycle
- iAccessSize, input, 2, 00 byte, 01 half, 10 word, 11 reserved
- iLoadUnsigned, input, 1, zero-extend sub-word loads (lbu/lhu)
- iAddress, input, DATA_W, ALU result used as address
- iStoreData, input, DATA_W, register rt data
- iMemReadData, input, DATA_W, word read from data memory
- iSwitch, input, IN_W, raw asynchronous switch pins
- oMemAddress, output, DATA_W, word-aligned address ({iAddress[31:2],2'b00})
- oMemWriteData, output, DATA_W, lane-replicated store data
- oMemByteEnable, output, 4, per-byte write enable
- oLoadData, output, DATA_W, data to register file
- oOutChannels, output, NUM_OUT_CH*OUT_W, channel k at bits [k*OUT_W +: OUT_W]
- oSwitchStable, output, IN_W, debounced switch value
- oFault, output, 1, sticky misaligned/illegal access flag

Behaviour:
- Reset (iReset high at a rising edge): all output channels 0; synchroniser 0; oSwitchStable 0; debounce counter 0; oFault 0.
- Decode is combinational, with isIo = (iAddress[31:10]==IO_BASE[31:10]).
- Misaligned: half with iAddress[0]=1; word with iAddress[1:0]!=0; size 11.
- IO illegal: any non-word IO access, or an IO address matching neither a channel nor SW_OFFSET.
- A bad access has no side effects: oMemByteEnable=0, no channel update, oLoadData=0.
- oFault is set on the next edge after a bad access with iDoLoad|iDoStore; it stays set until reset.
- Stores to memory (isIo=0, aligned):
  - byte: oMemWriteData = {4{iStoreData[7:0]}}, enable = 1<<iAddress[1:0]
  - half: oMemWriteData = {2{iStoreData[15:0]}}, enable = iAddress[1] ? 1100 : 0011
  - word: oMemWriteData = iStoreData, enable = 1111
- When no valid memory store occurs, oMemByteEnable = 0.
- Loads from memory: select the byte or half lane by iAddress[1:0], then sign- or zero-extend per iLoadUnsigned. Word loads pass through. Zero latency (combinational).
- IO store to IO_BASE+4k (k<NUM_OUT_CH): channel k <= iStoreData[OUT_W-1:0] at the next edge. Values hold until rewritten or reset.
- IO load at IO_BASE+4k returns {zero, channel k}. IO load at SW_OFFSET returns {zero, oSwitchStable}.
- iDoLoad and iDoStore both high: treated as bad access; oFault sets; no write.
- With iDoLoad=0, oLoadData=0.
- Switch path:
  - SYNC_STAGES-deep flop chain, then a debouncer.
  - Counter resets to 0 whenever the synced value equals oSwitchStable, or changes from the previous cycle.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, oSwitchStable <= synced value and the counter clears.
  - The counter saturates safely and never wraps.
- Reset mid-bounce discards the pending value.

Decomposition:
- Shared package mmio_pkg: access-size codes (SIZE_BYTE/HALF/WORD), IO_BASE, SW_OFFSET, per-channel offsets, lane-select function.
- One natural sub-module: switch_debouncer (synchroniser + counter, parameters IN_W, SYNC_STAGES, DEBOUNCE_CYCLES). The remaining steering logic stays in mmio_data_router.

Test Plan:
- Reset, then sb of 0x000000A5 to 0x00000013 → oMemByteEnable=1000, oMemWriteData=0xA5A5A5A5; lb with iMemReadData=0x80000000 at 0x3 → oLoadData=0xFFFFFF80; lbu → 0x00000080.
- sh to 0x00000006 with data 0x1234 → enable 1100; lh with iMemReadData=0x8001_0000 at 0x6 → 0xFFFF8001.
- sw 0x0000BEEF to 0xFFFFFC00, then 0x00000F0F to 0xFFFFFC04 → next edge: ch0=0xBEEF, ch1=0x0F0F; lw 0xFFFFFC04 → 0x00000F0F; memory enable stays 0000.
- sw to 0x00000002 → no write, enable 0000, oFault=1 the next cycle and held; sh to 0xFFFFFC00 → channel unchanged, oFault=1.
- DEBOUNCE_CYCLES=8: iSwitch 0x0000→0x00FF with a 3-cycle glitch back to 0 → oSwitchStable stays 0; held steady → updates to 0x00FF exactly SYNC_STAGES+8 cycles after the last change; lw 0xFFFFFC70 → 0x000000FF.
- iReset asserted mid-debounce and with channels non-zero → all channels, oSwitchStable and oFault read 0 the next cycle.
